// File: rtl/ts_frame_scheduler.sv
// ts_frame_scheduler: builds the per-byte control stream for the sync-invert /
// PRBS randomizer. Each frame is PKT_LEN transport bytes followed by CHK_LEN
// check slots, paced by the downstream strobe iEn. At every packet boundary
// the frame is filled either from the incoming TS or from an internal null
// packet generator, so the randomizer always sees a full-rate, well-formed
// frame, even when the input is absent or malformed.
module ts_frame_scheduler #(
    parameter int         PKT_LEN    = 188,
    parameter int         CHK_LEN    = 16,
    parameter logic [7:0] SYNC_BYTE  = 8'h47,
    parameter logic [7:0] STUFF_BYTE = 8'hFF
) (
    input  logic        iClk,
    input  logic        iClrn,
    input  logic        iEn,
    input  logic [7:0]  iData,
    input  logic        iValid,
    input  logic        iSop,
    output logic        oReady,
    output logic [7:0]  oData,
    output logic        oValid,
    output logic        oPSync,
    output logic        oCheck,
    output logic [15:0] oNullCnt,
    output logic [7:0]  oErrCnt
);

    localparam int FRAME_LEN = PKT_LEN + CHK_LEN;
    localparam int IDX_W     = $clog2(FRAME_LEN);

    localparam logic [IDX_W-1:0] LAST_PAYLOAD = IDX_W'(PKT_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_CHECK   = IDX_W'(FRAME_LEN - 1);

    localparam logic [1:0] ST_SYNC    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;

    logic [1:0]       state,    stateNxt;
    logic [IDX_W-1:0] idx,      idxNxt;
    logic             srcTs,    srcTsNxt;   // 1: frame carries input TS, 0: null packet
    logic             abort,    abortNxt;   // input packet given up, stuff the rest
    logic [7:0]       dataNxt;
    logic             pSyncNxt;
    logic             checkNxt;
    logic             errInc;
    logic             nullInc;

    // Null packet: PID 0x1FFF with payload-only adaptation control, then stuffing.
    function automatic logic [7:0] nullByte(input logic [IDX_W-1:0] pos);
        case (pos)
            IDX_W'(1): nullByte = 8'h1F;
            IDX_W'(2): nullByte = 8'hFF;
            IDX_W'(3): nullByte = 8'h10;
            default:   nullByte = STUFF_BYTE;
        endcase
    endfunction

    // An input byte is taken at every packet boundary (sop or dropped garbage)
    // and during a live TS payload, except a premature sop that must be kept
    // upstream for the next boundary.
    assign oReady = iEn && ((state == ST_SYNC) ||
                            (state == ST_PAYLOAD && srcTs && !abort && !(iValid && iSop)));

    // Next-state, next-output and counter-increment decisions for one strobe.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        stateNxt = state;
        idxNxt   = idx;
        srcTsNxt = srcTs;
        abortNxt = abort;
        dataNxt  = oData;
        pSyncNxt = oPSync;
        checkNxt = oCheck;
        errInc   = 1'b0;
        nullInc  = 1'b0;

        if (iEn) begin
            case (state)
                ST_SYNC: begin
                    dataNxt  = SYNC_BYTE;
                    pSyncNxt = 1'b1;
                    checkNxt = 1'b0;
                    abortNxt = 1'b0;
                    idxNxt   = IDX_W'(1);
                    stateNxt = ST_PAYLOAD;
                    if (iValid && iSop) begin
                        srcTsNxt = 1'b1;
                        errInc   = (iData != SYNC_BYTE);
                    end else begin
                        // Non-sop bytes here are dropped and counted as errors.
                        srcTsNxt = 1'b0;
                        nullInc  = 1'b1;
                        errInc   = iValid;
                    end
                end

                ST_PAYLOAD: begin
                    pSyncNxt = 1'b0;
                    checkNxt = 1'b0;
                    idxNxt   = idx + IDX_W'(1);
                    if (idx == LAST_PAYLOAD) begin
                        stateNxt = ST_CHECK;
                    end
                    if (srcTs && !abort) begin
                        if (iValid && !iSop) begin
                            dataNxt = iData;
                        end else begin
                            // Underrun or misaligned sop: one error, stuff the rest.
                            abortNxt = 1'b1;
                            errInc   = 1'b1;
                            dataNxt  = STUFF_BYTE;
                        end
                    end else if (srcTs) begin
                        dataNxt = STUFF_BYTE;
                    end else begin
                        dataNxt = nullByte(idx);
                    end
                end

                ST_CHECK: begin
                    dataNxt  = 8'h00;
                    pSyncNxt = 1'b0;
                    checkNxt = 1'b1;
                    if (idx == LAST_CHECK) begin
                        idxNxt   = '0;
                        stateNxt = ST_SYNC;
                    end else begin
                        idxNxt = idx + IDX_W'(1);
                    end
                end

                default: begin
                    idxNxt   = '0;
                    stateNxt = ST_SYNC;
                end
            endcase
        end
    end

    // Registered frame state, output byte (latency 1 per strobe) and counters.
    always_ff @(posedge iClk or negedge iClrn) begin
        if (!iClrn) begin
            state    <= ST_SYNC;
            idx      <= '0;
            srcTs    <= 1'b0;
            abort    <= 1'b0;
            oData    <= 8'h00;
            oValid   <= 1'b0;
            oPSync   <= 1'b0;
            oCheck   <= 1'b0;
            oNullCnt <= 16'h0000;
            oErrCnt  <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values computed above, independent of statement order.
            state  <= stateNxt;
            idx    <= idxNxt;
            srcTs  <= srcTsNxt;
            abort  <= abortNxt;
            oData  <= dataNxt;
            oValid <= iEn;
            oPSync <= pSyncNxt;
            oCheck <= checkNxt;
            if (nullInc && oNullCnt != 16'hFFFF) begin
                oNullCnt <= oNullCnt + 16'd1;
            end
            if (errInc && oErrCnt != 8'hFF) begin
                oErrCnt <= oErrCnt + 8'd1;
            end
        end
    end

endmodule
